// File: rtl/ins_cache_nway.sv
// ins_cache_nway: N-way set-associative instruction cache with true-LRU age counters,
// valid/ready command handshake and req/ack refill from the next level.
module ins_cache_nway #(
    parameter int WAYS        = 4,
    parameter int INDEX_BITS  = 14,
    parameter int OFFSET_BITS = 6,
    parameter int ADDR_BITS   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    input  logic [3:0]                       n,
    input  logic [ADDR_BITS-1:0]             add_in,
    output logic                             cmd_ready,
    output logic                             mem_req,
    output logic [ADDR_BITS-OFFSET_BITS-1:0] mem_addr,
    input  logic                             mem_ack,
    output logic [31:0]                      hit,
    output logic [31:0]                      miss,
    output logic [31:0]                      reads
);
    localparam int SETS     = 2**INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int AW       = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LW       = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MISS} state_t;

    state_t                r_state;
    logic [INDEX_BITS-1:0] r_ptr;
    logic [AW-1:0]         r_vic;
    logic [WAYS-1:0]       r_valid [SETS];
    logic [TAG_BITS-1:0]   r_tag   [SETS][WAYS];
    logic [AW-1:0]         r_age   [SETS][WAYS];

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic                  w_any_inv;
    logic [AW-1:0]         w_hw;
    logic [AW-1:0]         w_iw;
    logic [AW-1:0]         w_lw;
    logic [AW-1:0]         w_vic;
    logic [AW-1:0]         w_tw;
    logic [AW-1:0]         w_age [WAYS];

    assign cmd_ready = r_state == S_IDLE;
    // While a refill is outstanding the set is addressed by the latched line address.
    assign w_idx = (r_state == S_MISS) ? mem_addr[INDEX_BITS-1:0] : add_in[OFFSET_BITS +: INDEX_BITS];
    assign w_tag = add_in[ADDR_BITS-1 -: TAG_BITS];
    assign w_vic = w_any_inv ? w_iw : w_lw;
    assign w_tw  = (r_state == S_MISS) ? r_vic : w_hw;

    always_comb begin
        w_hit     = 1'b0;
        w_hw      = '0;
        w_any_inv = 1'b0;
        w_iw      = '0;
        w_lw      = '0;
        for (int i = WAYS-1; i >= 0; i--) begin
            if (r_valid[w_idx][i] && r_tag[w_idx][i] == w_tag) begin
                w_hit = 1'b1;
                w_hw  = AW'(i);
            end
            if (!r_valid[w_idx][i]) begin
                w_any_inv = 1'b1;
                w_iw      = AW'(i);
            end
            if (r_age[w_idx][i] == AW'(WAYS-1))
                w_lw = AW'(i);
        end
        for (int i = 0; i < WAYS; i++)
            w_age[i] = (AW'(i) == w_tw) ? '0 :
                       (r_age[w_idx][i] < r_age[w_idx][w_tw]) ? r_age[w_idx][i] + 1'b1 : r_age[w_idx][i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_CLEAR;
            r_ptr    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            hit      <= '0;
            miss     <= '0;
            reads    <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_valid[r_ptr] <= '0;
                    for (int i = 0; i < WAYS; i++) begin
                        r_tag[r_ptr][i] <= '0;
                        r_age[r_ptr][i] <= AW'(i);
                    end
                    r_ptr <= r_ptr + 1'b1;
                    if (&r_ptr)
                        r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (cmd_valid && n == 4'd8) begin
                        hit     <= '0;
                        miss    <= '0;
                        reads   <= '0;
                        r_ptr   <= '0;
                        r_state <= S_CLEAR;
                    end else if (cmd_valid && n == 4'd3) begin
                        if (w_hit)
                            r_valid[w_idx][w_hw] <= 1'b0;
                    end else if (cmd_valid && n == 4'd2) begin
                        reads <= reads + 32'd1;
                        if (w_hit) begin
                            hit <= hit + 32'd1;
                            for (int i = 0; i < WAYS; i++)
                                r_age[w_idx][i] <= w_age[i];
                        end else begin
                            miss     <= miss + 32'd1;
                            mem_addr <= add_in[ADDR_BITS-1:OFFSET_BITS];
                            r_vic    <= w_vic;
                            mem_req  <= 1'b1;
                            r_state  <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (mem_ack) begin
                        r_valid[w_idx][r_vic] <= 1'b1;
                        r_tag[w_idx][r_vic]   <= mem_addr[LW-1 -: TAG_BITS];
                        for (int i = 0; i < WAYS; i++)
                            r_age[w_idx][i] <= w_age[i];
                        mem_req <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (!rst && cmd_valid && cmd_ready && n == 4'd9)
            for (int s = 0; s < SETS; s++)
                if (|r_valid[s])
                    for (int i = 0; i < WAYS; i++)
                        $display("set %0h way %0d age %0d valid %0b tag %0h",
                                 s, i, r_age[s][i], r_valid[s][i], r_tag[s][i]);
`endif
endmodule

// File: tb/tb_ins_cache_nway.sv
// tb_ins_cache_nway: directed vector table plus hand sequences for clear, refill and reset-during-miss.
module tb_ins_cache_nway;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  n = 4'd0;
    logic [31:0] add_in = '0;
    logic        cmd_ready;
    logic        mem_req;
    logic [25:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] hit, miss, reads;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        int          d;
        bit          em;
        int          eh;
        int          emi;
        int          er;
    } vec_t;
    vec_t v[$];

    ins_cache_nway dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .n(n), .add_in(add_in),
        .cmd_ready(cmd_ready), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .hit(hit), .miss(miss), .reads(reads)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int eh, input int emi, input int er);
        chk({nm, " hit"}, hit, eh);
        chk({nm, " miss"}, miss, emi);
        chk({nm, " reads"}, reads, er);
    endtask

    task automatic wait_clear(input int start, input string nm);
        int cnt;
        cnt = start;
        while (!cmd_ready && cnt < 20000) begin
            cyc();
            cnt++;
        end
        chk(nm, cnt, 16384);
    endtask

    task automatic add(input logic [3:0] c, input logic [31:0] a, input int d,
                       input bit em, input int eh, input int emi, input int er);
        v.push_back('{c, a, d, em, eh, emi, er});
    endtask

    // Issue one command; if it misses, hold ack low for d-1 cycles and raise it on the d-th.
    task automatic op(input logic [3:0] cn, input logic [31:0] a, input int d, output bit was_miss);
        int hi;
        cmd_valid = 1'b1;
        n = cn;
        add_in = a;
        cyc();
        cmd_valid = 1'b0;
        was_miss = mem_req;
        if (mem_req) begin
            chk("miss_addr", mem_addr, a[31:6]);
            hi = 0;
            for (int k = 1; k <= d; k++) begin
                if (mem_req && !cmd_ready && mem_addr == a[31:6])
                    hi++;
                mem_ack = (k == d);
                cyc();
            end
            mem_ack = 1'b0;
            chk("req_cycles", hi, d);
            chk("req_drop", mem_req, 0);
            chk("ready_back", cmd_ready, 1);
        end
    endtask

    initial begin
        bit wm;
        // set 1: tag<<20 | 0x40, set 5: | 0x140, set 7: | 0x1C0
        add(4'd2, 32'h0000_0040, 3, 1, 0, 1, 1);
        add(4'd2, 32'h0000_0044, 1, 0, 1, 1, 2);
        add(4'd8, 32'h0000_0000, 1, 0, 0, 0, 0);
        add(4'd2, 32'h0010_0040, 1, 1, 0, 1, 1);
        add(4'd2, 32'h0020_0040, 2, 1, 0, 2, 2);
        add(4'd2, 32'h0030_0040, 1, 1, 0, 3, 3);
        add(4'd2, 32'h0040_0040, 1, 1, 0, 4, 4);
        add(4'd2, 32'h0050_0040, 2, 1, 0, 5, 5);
        add(4'd2, 32'h0010_0040, 1, 1, 0, 6, 6);
        add(4'd2, 32'h00A0_0140, 1, 1, 0, 7, 7);
        add(4'd2, 32'h00B0_0140, 1, 1, 0, 8, 8);
        add(4'd2, 32'h00C0_0140, 1, 1, 0, 9, 9);
        add(4'd2, 32'h00D0_0140, 1, 1, 0, 10, 10);
        add(4'd2, 32'h00A0_0140, 1, 0, 1, 10, 11);
        add(4'd2, 32'h00E0_0140, 2, 1, 1, 11, 12);
        add(4'd2, 32'h00A0_0140, 1, 0, 2, 11, 13);
        add(4'd2, 32'h00C0_0140, 1, 0, 3, 11, 14);
        add(4'd2, 32'h00D0_0140, 1, 0, 4, 11, 15);
        add(4'd2, 32'h00B0_0140, 1, 1, 4, 12, 16);
        add(4'd2, 32'h00E0_0140, 1, 1, 4, 13, 17);
        add(4'd2, 32'h00B0_0140, 1, 0, 5, 13, 18);
        add(4'd2, 32'h0010_01C0, 1, 1, 5, 14, 19);
        add(4'd2, 32'h0020_01C0, 1, 1, 5, 15, 20);
        add(4'd2, 32'h0030_01C0, 1, 1, 5, 16, 21);
        add(4'd2, 32'h0040_01C0, 1, 1, 5, 17, 22);
        add(4'd3, 32'h0020_01C0, 1, 0, 5, 17, 22);
        add(4'd3, 32'h0090_01C0, 1, 0, 5, 17, 22);
        add(4'd2, 32'h0020_01C0, 1, 1, 5, 18, 23);
        add(4'd2, 32'h0010_01C0, 1, 0, 6, 18, 24);
        add(4'd2, 32'h0030_01C0, 1, 0, 7, 18, 25);
        add(4'd2, 32'h0040_01C0, 1, 0, 8, 18, 26);
        add(4'd2, 32'h0020_01C0, 1, 0, 9, 18, 27);
        add(4'd9, 32'h0000_0000, 1, 0, 9, 18, 27);
        add(4'd5, 32'h0090_01C0, 1, 0, 9, 18, 27);
        add(4'd2, 32'h0090_01C0, 1, 1, 9, 19, 28);
        add(4'd2, 32'h0010_01C0, 2, 1, 9, 20, 29);
        add(4'd2, 32'h0020_01C0, 1, 0, 10, 20, 30);

        cmd_valid = 1'b1;
        n = 4'd2;
        add_in = 32'h0000_0040;
        cyc();
        cyc();
        chk("rst ready", cmd_ready, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk_cnt("rst", 0, 0, 0);
        rst = 1'b0;
        wait_clear(0, "reset clear cycles");
        cmd_valid = 1'b0;
        chk_cnt("after clear", 0, 0, 0);

        foreach (v[i]) begin
            op(v[i].c, v[i].a, v[i].d, wm);
            if (v[i].c == 4'd8)
                wait_clear(0, "n8 clear cycles");
            chk($sformatf("v%0d missflag", i), wm, v[i].em);
            chk_cnt($sformatf("v%0d", i), v[i].eh, v[i].emi, v[i].er);
        end

        // stray ack and unaccepted fetch must be ignored
        n = 4'd2;
        add_in = 32'h0030_01C0;
        mem_ack = 1'b1;
        cyc();
        cyc();
        mem_ack = 1'b0;
        chk("stray ack req", mem_req, 0);
        chk("stray ack ready", cmd_ready, 1);
        chk_cnt("unaccepted", 10, 20, 30);

        // reset one cycle into a miss, then a late ack
        cmd_valid = 1'b1;
        n = 4'd2;
        add_in = 32'h0070_0200;
        cyc();
        cmd_valid = 1'b0;
        chk("midmiss req", mem_req, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midmiss rst req", mem_req, 0);
        chk("midmiss rst addr", mem_addr, 0);
        chk("midmiss rst ready", cmd_ready, 0);
        chk_cnt("midmiss rst", 0, 0, 0);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("late ack req", mem_req, 0);
        wait_clear(1, "midmiss clear cycles");
        op(4'd2, 32'h0070_0200, 1, wm);
        chk("post rst missflag", wm, 1);
        chk_cnt("post rst", 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ins_cache_nway.md
# ins_cache_nway

Parametrised N-way set-associative instruction cache, the successor of the fixed 2-way 16K-set instruction cache. It decodes the same trace command codes: 8 clear, 3 invalidate, 2 fetch, 9 print. It replaces the single-bit LRU with true LRU age counters and adds a valid/ready command handshake plus a req/ack miss handshake to the next-level cache. It sits between the trace driver and the next-level cache and feeds the statistics module.

## Interface
- WAYS, 4, associativity; power of two, 1..8
- INDEX_BITS, 14, set-index width; SETS = 2**INDEX_BITS
- OFFSET_BITS, 6, line-offset width (64-byte lines)
- ADDR_BITS, 32, address width; TAG_BITS = ADDR_BITS-INDEX_BITS-OFFSET_BITS (derived, 12 by default)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- n  in  4  trace command code
- add_in  in  ADDR_BITS  trace address
- cmd_ready  out  1  command accepted on any edge where cmd_valid && cmd_ready
- mem_req  out  1  line read request to next level
- mem_addr  out  ADDR_BITS-OFFSET_BITS  line address add_in[ADDR_BITS-1:OFFSET_BITS] of the missing fetch
- mem_ack  in  1  next level done; sampled only while mem_req=1
- hit, miss, reads  out  32 each  statistics counters; wrap modulo 2**32

## Operation
- State per set: valid[WAYS], tag[WAYS], age[WAYS] of log2(WAYS) bits. The ages always form a permutation of 0..WAYS-1; age 0 is MRU.
- Address split: tag = add_in[ADDR_BITS-1 -: TAG_BITS], index = add_in[OFFSET_BITS +: INDEX_BITS].
- FSM states:
  - CLEAR: walks index 0..SETS-1, one set per cycle. Each set gets valid=0, tag=0, age[w]=w. cmd_ready=0. Goes to IDLE after the set at SETS-1 is cleared.
  - IDLE: cmd_ready=1.
  - MISS: cmd_ready=0, mem_req=1.
- Reset (rst=1 on an edge):
  - State goes to CLEAR with the walk pointer at 0.
  - hit, miss and reads go to 0; mem_req goes to 0; mem_addr goes to 0.
  - This applies from any state, including mid-MISS (the request is dropped, no fill) and mid-CLEAR (the walk restarts).
- Accepted command codes:
  - n=8: zero all counters and enter CLEAR.
  - n=3, invalidate: clear valid of the way with a valid tag match. No match means no change. LRU is unchanged and counters are unchanged.
  - n=2, fetch: reads+1.
    - Hit (valid && tag match): hit+1, touch that way, stay in IDLE.
    - Miss: miss+1, latch mem_addr and the victim way, enter MISS.
    - Victim is the lowest-numbered invalid way; if none is invalid, the way with age WAYS-1.
  - n=9: simulation-only $display of every set with any valid way (index, ages, valid and tag per way). No state change.
  - Any other code: consumed with no effect.
- Touch of way w: every way whose age is less than age[w] increments; age[w] becomes 0. Ways with age greater than age[w] are unchanged.
- Fill happens in MISS on the edge where mem_ack=1: victim gets valid=1, tag written, touch applied; return to IDLE. An invalidate to the victim's set cannot interleave, because commands are blocked in MISS.
- Unaccepted cycles (cmd_valid=0 or cmd_ready=0) cause no state or counter change.

## Timing
- Hit, invalidate and print occupy 1 cycle. Back-to-back commands are accepted on every edge.
- Miss:
  - Accepted at edge E; mem_req and mem_addr are valid after E.
  - Both are held stable until the edge where mem_ack=1 (earliest E+1). The fill occurs on that edge and mem_req drops after it.
  - cmd_ready rises after the fill edge. Minimum occupancy is 2 cycles.
- Counters update on the acceptance edge (hit/miss are decided then, not at fill).
- Clear takes SETS cycles after the rst/n=8 edge. cmd_ready rises after the edge that clears set SETS-1.
- If mem_ack=1 while mem_req=0, it is ignored.

## Test plan
- Reset, then hold cmd_valid=1, n=2 -> cmd_ready=0 for exactly 16384 cycles; hit=miss=reads=0.
- Fetch 0x0000_0040, ack after 3 cycles -> miss=1, mem_addr=0x000001, mem_req high 3 cycles; re-fetch 0x0000_0044 -> hit=1, single cycle.
- Five distinct tags 0x001..0x005 into index 0x0001 with WAYS=4, then 0x001 again -> fifth fill evicts tag 0x001 (way 0, age 3); final fetch misses; miss=6, hit=0.
- Tags A,B,C,D fill set 5, re-touch A, fetch E -> E replaces B (way 1); later fetch of A hits.
- Invalidate a cached tag, then fetch it -> miss, and the refill goes into the freed way (lowest invalid); invalidating an absent tag changes nothing.
- rst asserted 1 cycle after a miss is accepted, mem_ack then pulsed -> mem_req=0 after the rst edge, no fill, counters 0, CLEAR restarts.
